// File: rtl/sim_run_ctrl_pkg.sv
// Shared definitions for the simulation/bring-up run controller: state
// encoding, exit-code constants and the default tohost address.
package sim_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } run_state_t;

    // A tohost write of EXIT_PASS means success; any other value is a failure code.
    localparam int unsigned EXIT_PASS = 1;

    // Wide enough to be sliced down to any data width up to 64 bits.
    localparam logic [63:0] EXIT_TIMEOUT = '1;

    localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_1000;

    // Width of the reset-hold and drain counters (both ranges are 0..255).
    localparam int HOLD_W = 8;

endpackage

// File: rtl/sim_run_ctrl_sat_counter.sv
// Saturating up-counter with enable and synchronous clear; it sticks at
// all-ones instead of wrapping so long runs never report a small count.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: holds the core in reset, watches for halt / tohost write /
// watchdog, latches the verdict, drains in-flight stores and reports done.
module sim_run_ctrl
    import sim_run_ctrl_pkg::*;
#(
    parameter int                 ADDR_W         = 32,
    parameter int                 DATA_W         = 32,
    parameter int                 CNT_W          = 32,
    parameter int unsigned        RESET_CYCLES   = 1,
    parameter int unsigned        TIMEOUT_CYCLES = 1000,
    parameter int unsigned        DRAIN_CYCLES   = 4,
    parameter logic [ADDR_W-1:0]  TOHOST_ADDR    = ADDR_W'(DEFAULT_TOHOST_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              imem_rd_enable,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic              dmem_w_enable,
    input  logic [DATA_W-1:0] dmem_w_data,
    input  logic              dmem_ready,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [DATA_W-1:0] exit_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DRAIN_LAST   = (DRAIN_CYCLES == 0) ? '0 : HOLD_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam run_state_t        AFTER_TERM   = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
    localparam logic              SKIP_DRAIN   = (DRAIN_CYCLES == 0);

    run_state_t        state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] drain_q;
    logic              core_reset_q;
    logic              running_q;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;
    logic [DATA_W-1:0] exit_q;

    logic              tohost_hit;
    logic              wdog_hit;
    logic              term_d;
    logic              pass_d;
    logic              timeout_d;
    logic [DATA_W-1:0] exit_d;

    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  fetch_cnt;
    logic              in_run;
    logic              in_hold;

    assign in_run  = (state_q == ST_RUN);
    assign in_hold = (state_q == ST_HOLD);

    // Counters only advance in RUN, so leaving RUN on the terminating edge
    // freezes them with that final cycle already counted.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (in_hold),
        .en_i    (in_run),
        .count_o (cycle_cnt)
    );

    sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .clr_i   (in_hold),
        .en_i    (in_run & imem_rd_enable),
        .count_o (fetch_cnt)
    );

    // Termination decode, highest priority first: tohost, halt, watchdog.
    always_comb begin
        tohost_hit = dmem_w_enable & dmem_ready & (dmem_addr == TOHOST_ADDR);
        wdog_hit   = (cycle_cnt == TIMEOUT_LAST);
        term_d     = tohost_hit | halt | wdog_hit;
        exit_d     = '0;
        pass_d     = 1'b0;
        timeout_d  = 1'b0;
        if (tohost_hit) begin
            exit_d = dmem_w_data;
            pass_d = (dmem_w_data == DATA_W'(EXIT_PASS));
        end else if (halt) begin
            pass_d = 1'b1;
        end else if (wdog_hit) begin
            exit_d    = EXIT_TIMEOUT[DATA_W-1:0];
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_q       <= '0;
            drain_q      <= '0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            exit_q       <= '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    hold_q <= hold_q + 1'b1;
                    if (hold_q == HOLD_LAST) begin
                        state_q      <= ST_RUN;
                        core_reset_q <= 1'b0;
                        running_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (term_d) begin
                        state_q   <= AFTER_TERM;
                        running_q <= 1'b0;
                        exit_q    <= exit_d;
                        pass_q    <= pass_d;
                        timeout_q <= timeout_d;
                        done_q    <= SKIP_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q <= ST_HOLD;
                end
            endcase
        end
    end

    assign core_reset  = core_reset_q;
    assign running     = running_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign exit_code   = exit_q;
    assign cycle_count = cycle_cnt;
    assign fetch_count = fetch_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl with RESET_CYCLES=3, TIMEOUT_CYCLES=20,
// DRAIN_CYCLES=2 and tohost at 0x100.
module tb_sim_run_ctrl;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        imem_rd_enable;
  logic [31:0] dmem_addr;
  logic        dmem_w_enable;
  logic [31:0] dmem_w_data;
  logic        dmem_ready;
  logic        core_reset;
  logic        running;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [31:0] exit_code;
  logic [31:0] cycle_count;
  logic [31:0] fetch_count;

  int checks;
  int failures;

  sim_run_ctrl #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .CNT_W          (32),
    .RESET_CYCLES   (3),
    .TIMEOUT_CYCLES (20),
    .DRAIN_CYCLES   (2),
    .TOHOST_ADDR    (32'h0000_0100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .halt           (halt),
    .imem_rd_enable (imem_rd_enable),
    .dmem_addr      (dmem_addr),
    .dmem_w_enable  (dmem_w_enable),
    .dmem_w_data    (dmem_w_data),
    .dmem_ready     (dmem_ready),
    .core_reset     (core_reset),
    .running        (running),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .exit_code      (exit_code),
    .cycle_count    (cycle_count),
    .fetch_count    (fetch_count)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: bench still running at %0t, required finish earlier", $time);
    $fatal(1, "time limit");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    halt           = 1'b0;
    imem_rd_enable = 1'b0;
    dmem_addr      = 32'h0;
    dmem_w_enable  = 1'b0;
    dmem_w_data    = 32'h0;
    dmem_ready     = 1'b0;
  endtask

  task automatic drive_write(input logic [31:0] addr, input logic [31:0] data, input logic rdy);
    dmem_addr     = addr;
    dmem_w_data   = data;
    dmem_w_enable = 1'b1;
    dmem_ready    = rdy;
  endtask

  // Leaves the bench 1ns after the edge that entered RUN (RUN cycle 0).
  task automatic start_run();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    checks++;
    if ({core_reset, running, done, pass, timeout} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_flags: got %b required 10000", {core_reset, running, done, pass, timeout});
    end
    checks++;
    if ({exit_code, cycle_count, fetch_count} !== 96'h0) begin
      failures++;
      $display("FAIL reset_values: got %h/%h/%h required zeros", exit_code, cycle_count, fetch_count);
    end
    step();
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (core_reset !== 1'b1 || running !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: got core_reset=%b running=%b required 1/0", c, core_reset, running);
      end
      step();
    end
    checks++;
    if (core_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL run_entry: got core_reset=%b running=%b cycles=%0d required 0/1/0", core_reset, running, cycle_count);
    end
    imem_rd_enable = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (cycle_count !== 32'd4 || fetch_count !== 32'd4) begin
      failures++;
      $display("FAIL run_counting: got cycles=%0d fetches=%0d required 4/4", cycle_count, fetch_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({core_reset, running, done} !== 3'b100 || cycle_count !== 32'd0 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL mid_run_reset: got cr/run/done=%b cycles=%0d fetches=%0d required 100/0/0",
               {core_reset, running, done}, cycle_count, fetch_count);
    end
    idle_inputs();
  endtask

  task automatic test_halt();
    start_run();
    for (int k = 0; k < 8; k++) begin
      imem_rd_enable = (k % 2 == 0);
      halt           = (k == 7);
      step();
    end
    idle_inputs();
    checks++;
    if (running !== 1'b0 || cycle_count !== 32'd8 || fetch_count !== 32'd4 || done !== 1'b0) begin
      failures++;
      $display("FAIL halt_term: got run=%b cycles=%0d fetches=%0d done=%b required 0/8/4/0",
               running, cycle_count, fetch_count, done);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL halt_drain1: got done=%b required 0", done);
    end
    step();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0 || exit_code !== 32'h0) begin
      failures++;
      $display("FAIL halt_done: got done=%b pass=%b timeout=%b exit=%h required 1/1/0/00000000",
               done, pass, timeout, exit_code);
    end
  endtask

  task automatic test_tohost(input logic [31:0] data, input logic exp_pass);
    start_run();
    for (int k = 0; k < 5; k++) step();
    drive_write(32'h100, data, 1'b1);
    step();
    idle_inputs();
    checks++;
    if (running !== 1'b0 || cycle_count !== 32'd6 || exit_code !== data || pass !== exp_pass || timeout !== 1'b0) begin
      failures++;
      $display("FAIL tohost_%h: got run=%b cycles=%0d exit=%h pass=%b timeout=%b required 0/6/%h/%b/0",
               data, running, cycle_count, exit_code, pass, timeout, data, exp_pass);
    end
    step();
    step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL tohost_done_%h: got done=%b required 1", data, done);
    end
  endtask

  task automatic test_ready_gate();
    start_run();
    step();
    step();
    drive_write(32'h100, 32'h55, 1'b0);
    step();
    idle_inputs();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL not_ready_write: got running=%b required 1", running);
    end
    step();
    drive_write(32'h100, 32'h55, 1'b1);
    step();
    idle_inputs();
    checks++;
    if (running !== 1'b0 || cycle_count !== 32'd5 || exit_code !== 32'h55 || pass !== 1'b0) begin
      failures++;
      $display("FAIL ready_write: got run=%b cycles=%0d exit=%h pass=%b required 0/5/00000055/0",
               running, cycle_count, exit_code, pass);
    end
    start_run();
    step();
    step();
    drive_write(32'h104, 32'h1, 1'b1);
    step();
    idle_inputs();
    checks++;
    if (running !== 1'b1 || cycle_count !== 32'd3 || exit_code !== 32'h0) begin
      failures++;
      $display("FAIL wrong_addr: got run=%b cycles=%0d exit=%h required 1/3/00000000", running, cycle_count, exit_code);
    end
  endtask

  task automatic test_watchdog();
    start_run();
    for (int k = 0; k < 19; k++) step();
    checks++;
    if (running !== 1'b1 || cycle_count !== 32'd19) begin
      failures++;
      $display("FAIL wdog_before: got run=%b cycles=%0d required 1/19", running, cycle_count);
    end
    step();
    checks++;
    if (running !== 1'b0 || cycle_count !== 32'd20 || timeout !== 1'b1 || pass !== 1'b0 || exit_code !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wdog_fire: got run=%b cycles=%0d timeout=%b pass=%b exit=%h required 0/20/1/0/ffffffff",
               running, cycle_count, timeout, pass, exit_code);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL wdog_drain1: got done=%b required 0", done);
    end
    step();
    step();
    checks++;
    if (done !== 1'b1 || cycle_count !== 32'd20 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL wdog_done: got done=%b cycles=%0d fetches=%0d required 1/20/0", done, cycle_count, fetch_count);
    end
  endtask

  task automatic test_priority();
    start_run();
    step();
    step();
    step();
    drive_write(32'h100, 32'h2A, 1'b1);
    halt = 1'b1;
    step();
    checks++;
    if (exit_code !== 32'h2A || pass !== 1'b0 || timeout !== 1'b0 || cycle_count !== 32'd4) begin
      failures++;
      $display("FAIL tohost_over_halt: got exit=%h pass=%b timeout=%b cycles=%0d required 0000002a/0/0/4",
               exit_code, pass, timeout, cycle_count);
    end
    // Halt and a passing tohost write stay asserted through DRAIN and must be ignored.
    drive_write(32'h100, 32'h1, 1'b1);
    imem_rd_enable = 1'b1;
    step();
    step();
    idle_inputs();
    checks++;
    if (done !== 1'b1 || exit_code !== 32'h2A || pass !== 1'b0 || cycle_count !== 32'd4 || fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL drain_ignore: got done=%b exit=%h pass=%b cycles=%0d fetches=%0d required 1/0000002a/0/4/0",
               done, exit_code, pass, cycle_count, fetch_count);
    end
    start_run();
    for (int k = 0; k < 19; k++) step();
    halt = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (timeout !== 1'b0 || pass !== 1'b1 || exit_code !== 32'h0 || cycle_count !== 32'd20 || running !== 1'b0) begin
      failures++;
      $display("FAIL halt_over_wdog: got timeout=%b pass=%b exit=%h cycles=%0d run=%b required 0/1/00000000/20/0",
               timeout, pass, exit_code, cycle_count, running);
    end
  endtask

  // scenario sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_halt();
    test_tohost(32'h1, 1'b1);
    test_tohost(32'h2A, 1'b0);
    test_ready_gate();
    test_watchdog();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
